// File: rtl/pmu_pkg.sv
// Shared PMU definitions: quota regulator state encoding and minimum period.
package pmu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        RUN      = 2'd2,
        THROTTLE = 2'd3
    } quota_reg_state_t;

    // Shortest period the regulator will run; keeps plen-1 from underflowing.
    localparam int unsigned PMU_MIN_PERIOD = 2;

endpackage

// File: rtl/pmu_sat_counter.sv
// Saturating up-counter with clear priority over increment.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - zero the count next cycle (wins over inc_i)
//   inc_i  - increment by one, holding at all-ones
//   cnt_o  - registered count
module pmu_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pmu_quota_regulator.sv
// Per-core budget regulator: splits time into replenishment periods, soft-resets
// the quota unit at each period start, throttles the core after a quota
// interrupt for the rest of the period, and counts overrun periods.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   en_i              - regulation enable
//   period_i          - period length in cycles (clamped to >= 2, latched in REFILL)
//   intr_quota_i      - quota-exceeded interrupt
//   clr_overrun_i     - clear overrun counter
//   quota_softrst_o   - soft reset to quota unit (IDLE and REFILL)
//   stall_o           - throttle request
//   intr_overrun_o    - one-cycle pulse per overrun period
//   overrun_cnt_o     - saturating overrun period count
//   timer_o           - cycle index within current period
module pmu_quota_regulator
    import pmu_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [REG_WIDTH-1:0] period_i,
    input  logic                 intr_quota_i,
    input  logic                 clr_overrun_i,
    output logic                 quota_softrst_o,
    output logic                 stall_o,
    output logic                 intr_overrun_o,
    output logic [REG_WIDTH-1:0] overrun_cnt_o,
    output logic [REG_WIDTH-1:0] timer_o
);

    localparam logic [REG_WIDTH-1:0] MIN_PERIOD = REG_WIDTH'(PMU_MIN_PERIOD);

    quota_reg_state_t     r_state;
    quota_reg_state_t     w_state_nxt;
    logic [REG_WIDTH-1:0] r_plen;
    logic [REG_WIDTH-1:0] r_timer;
    logic                 r_softrst;
    logic                 r_stall;
    logic                 r_intr_overrun;
    logic [REG_WIDTH-1:0] w_period_clamped;
    logic                 w_period_end;
    logic                 w_overrun_evt;
    logic                 w_in_period;

    assign w_period_clamped = (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
    assign w_in_period      = (r_state == RUN) || (r_state == THROTTLE);
    // r_plen >= 2 whenever a period is running, so plen-1 cannot wrap.
    assign w_period_end     = w_in_period && (r_timer == (r_plen - REG_WIDTH'(1)));

    // Next-state and overrun event decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_evt = 1'b0;
        if (!en_i) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:   w_state_nxt = REFILL;
                REFILL: w_state_nxt = RUN;
                RUN: begin
                    // Overrun is counted even when it lands on the last cycle.
                    w_overrun_evt = intr_quota_i;
                    if (w_period_end) begin
                        w_state_nxt = REFILL;
                    end else if (intr_quota_i) begin
                        w_state_nxt = THROTTLE;
                    end
                end
                THROTTLE: begin
                    if (w_period_end) begin
                        w_state_nxt = REFILL;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, period latch, timer and registered outputs derived from next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_plen         <= MIN_PERIOD;
            r_timer        <= '0;
            r_softrst      <= 1'b0;
            r_stall        <= 1'b0;
            r_intr_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == REFILL) begin
                r_plen <= w_period_clamped;
            end
            if ((w_state_nxt == RUN) || (w_state_nxt == THROTTLE)) begin
                r_timer <= r_timer + REG_WIDTH'(1);
            end else begin
                r_timer <= '0;
            end
            r_softrst      <= (w_state_nxt == IDLE) || (w_state_nxt == REFILL);
            r_stall        <= (w_state_nxt == THROTTLE);
            r_intr_overrun <= w_overrun_evt;
        end
    end

    pmu_sat_counter #(
        .WIDTH (REG_WIDTH)
    ) u_overrun_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_overrun_i),
        .inc_i (w_overrun_evt),
        .cnt_o (overrun_cnt_o)
    );

    assign quota_softrst_o = r_softrst;
    assign stall_o         = r_stall;
    assign intr_overrun_o  = r_intr_overrun;
    assign timer_o         = r_timer;

endmodule

// File: tb/tb_pmu_quota_regulator.sv
// Self-checking bench for pmu_quota_regulator: a behavioural period model
// pushes expected outputs when stimulus is driven; they are popped and
// compared after the clock edge.
module tb_pmu_quota_regulator;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         softrst;
        logic         stall;
        logic         pulse;
        logic [W-1:0] cnt;
        logic [W-1:0] tmr;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] period;
    logic         intr_quota;
    logic         clr_overrun;
    logic         quota_softrst;
    logic         stall;
    logic         intr_overrun;
    logic [W-1:0] overrun_cnt;
    logic [W-1:0] timer;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q_exp[$];

    // Model: phase 0 = idle, 1 = refill, 2 = inside period.
    int           m_ph   = 0;
    logic         m_thr  = 1'b0;
    logic [W-1:0] m_tmr  = '0;
    logic [W-1:0] m_plen = W'(2);
    logic [W-1:0] m_cnt  = '0;

    pmu_quota_regulator #(
        .REG_WIDTH (W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .period_i        (period),
        .intr_quota_i    (intr_quota),
        .clr_overrun_i   (clr_overrun),
        .quota_softrst_o (quota_softrst),
        .stall_o         (stall),
        .intr_overrun_o  (intr_overrun),
        .overrun_cnt_o   (overrun_cnt),
        .timer_o         (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge and return the expected outputs.
    task automatic model(input logic e, input logic [W-1:0] p, input logic iq,
                         input logic clr, input logic r, output exp_t x);
        logic ev;
        ev = 1'b0;
        if (r) begin
            m_ph = 0; m_thr = 1'b0; m_tmr = '0; m_cnt = '0;
            x = '0;
            return;
        end
        if (!e) begin
            m_ph = 0; m_thr = 1'b0; m_tmr = '0;
        end else if (m_ph == 0) begin
            m_ph = 1; m_tmr = '0; m_thr = 1'b0;
        end else if (m_ph == 1) begin
            m_plen = (p < W'(2)) ? W'(2) : p;
            m_ph = 2; m_tmr = W'(1); m_thr = 1'b0;
        end else if (m_tmr == m_plen - W'(1)) begin
            ev = iq && !m_thr;
            m_ph = 1; m_tmr = '0; m_thr = 1'b0;
        end else begin
            if (iq && !m_thr) begin
                ev = 1'b1; m_thr = 1'b1;
            end
            m_tmr = m_tmr + W'(1);
        end
        if (clr) m_cnt = '0;
        else if (ev && m_cnt != {W{1'b1}}) m_cnt = m_cnt + W'(1);
        x.softrst = (m_ph != 2);
        x.stall   = m_thr;
        x.pulse   = ev;
        x.cnt     = m_cnt;
        x.tmr     = m_tmr;
    endtask

    // Drive one cycle of stimulus, push expectation, compare after the edge.
    task automatic step(input logic e, input logic [W-1:0] p, input logic iq,
                        input logic clr, input logic r);
        exp_t x;
        @(negedge clk);
        en = e; period = p; intr_quota = iq; clr_overrun = clr; rst = r;
        model(e, p, iq, clr, r, x);
        q_exp.push_back(x);
        @(posedge clk);
        #1;
        x = q_exp.pop_front();
        check("softrst", 32'(quota_softrst), 32'(x.softrst));
        check("stall",   32'(stall),         32'(x.stall));
        check("pulse",   32'(intr_overrun),  32'(x.pulse));
        check("cnt",     32'(overrun_cnt),   32'(x.cnt));
        check("timer",   32'(timer),         32'(x.tmr));
    endtask

    // Run with quiet inputs until the model sits at timer index t inside a period.
    task automatic run_to(input logic [W-1:0] t, input logic [W-1:0] p, input int bound);
        int n;
        n = 0;
        while (!(m_ph == 2 && m_tmr == t) && n < bound) begin
            step(1'b1, p, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check("run_to_bound", 32'(n < bound), 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = W'(10); intr_quota = 1'b0; clr_overrun = 1'b0;

        // Reset, then idle with enable low.
        repeat (3) step(1'b0, W'(10), 1'b0, 1'b0, 1'b1);
        check("rst_softrst", 32'(quota_softrst), 32'd0);
        repeat (3) step(1'b0, W'(10), 1'b0, 1'b0, 1'b0);
        check("idle_softrst", 32'(quota_softrst), 32'd1);
        check("idle_timer",   32'(timer),         32'd0);

        // Plain periods, no overrun.
        repeat (25) step(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        check("quiet_cnt", 32'(overrun_cnt), 32'd0);

        // Overrun raised at timer 4.
        run_to(W'(4), W'(10), 20);
        step(1'b1, W'(10), 1'b1, 1'b0, 1'b0);
        check("ovr_stall", 32'(stall),        32'd1);
        check("ovr_pulse", 32'(intr_overrun), 32'd1);
        check("ovr_timer", 32'(timer),        32'd5);
        check("ovr_cnt",   32'(overrun_cnt),  32'd1);
        run_to(W'(9), W'(10), 20);
        check("ovr_hold", 32'(stall), 32'd1);
        step(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        check("refill_stall",   32'(stall),         32'd0);
        check("refill_softrst", 32'(quota_softrst), 32'd1);

        // Interrupt on the last cycle of the period.
        run_to(W'(9), W'(10), 20);
        step(1'b1, W'(10), 1'b1, 1'b0, 1'b0);
        check("coll_pulse",   32'(intr_overrun),  32'd1);
        check("coll_stall",   32'(stall),         32'd0);
        check("coll_softrst", 32'(quota_softrst), 32'd1);
        check("coll_cnt",     32'(overrun_cnt),   32'd2);

        // Period change mid-period only applies after the next REFILL.
        run_to(W'(3), W'(10), 20);
        repeat (6) step(1'b1, W'(0), 1'b0, 1'b0, 1'b0);
        check("live_timer", 32'(timer), 32'd9);
        repeat (4) step(1'b1, W'(0), 1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b1, W'(5), 1'b0, 1'b0, 1'b0);

        // Saturation with minimum period and interrupt held high.
        repeat (540) step(1'b1, W'(0), 1'b1, 1'b0, 1'b0);
        check("sat_cnt", 32'(overrun_cnt), 32'hFF);

        // Clear on an increment cycle.
        for (int i = 0; i < 4 && m_ph != 2; i++) step(1'b1, W'(0), 1'b1, 1'b0, 1'b0);
        step(1'b1, W'(0), 1'b1, 1'b1, 1'b0);
        check("clr_cnt",   32'(overrun_cnt),  32'd0);
        check("clr_pulse", 32'(intr_overrun), 32'd1);

        // Disable during THROTTLE.
        run_to(W'(3), W'(10), 30);
        step(1'b1, W'(10), 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        check("thr_stall", 32'(stall), 32'd1);
        step(1'b0, W'(10), 1'b0, 1'b0, 1'b0);
        check("dis_stall",   32'(stall),         32'd0);
        check("dis_softrst", 32'(quota_softrst), 32'd1);
        check("dis_timer",   32'(timer),         32'd0);

        // Reset mid-operation, then release with enable low.
        repeat (4) step(1'b1, W'(10), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'(10), 1'b0, 1'b0, 1'b1);
        check("mrst_softrst", 32'(quota_softrst), 32'd0);
        check("mrst_timer",   32'(timer),         32'd0);
        step(1'b0, W'(10), 1'b0, 1'b0, 1'b0);
        check("post_softrst", 32'(quota_softrst), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
